// File: rtl/key_event_if.sv
// Event handshake between key_event_queue (master, producer) and the game logic (slave).
interface key_event_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_code;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/key_event_queue.sv
// USB HID keycode to queued game events: sync + torn-word filter, press edges, FIFO.
// Frame-timed auto-repeat of direction keys is built only when KEY_AUTOREPEAT_EN is defined.
module key_event_queue #(
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 12,
  parameter int REPEAT_RATE  = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        vs,
  key_event_if.master ev,
  output logic        overflow,
  output logic        held
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // {mapped, code}; direction codes are 0..3 so bit 2 clear marks a direction
  function automatic logic [3:0] f_map(input logic [7:0] k);
    case (k)
      8'h1A:   f_map = 4'b1_000;
      8'h04:   f_map = 4'b1_001;
      8'h16:   f_map = 4'b1_010;
      8'h07:   f_map = 4'b1_011;
      8'h2C:   f_map = 4'b1_100;
      8'h28:   f_map = 4'b1_101;
      default: f_map = 4'b0_000;
    endcase
  endfunction

  logic [7:0] r_key_s1, r_key_s2, r_key_s3, r_key_filt, r_key_last;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_key_s1   <= '0;
      r_key_s2   <= '0;
      r_key_s3   <= '0;
      r_key_filt <= '0;
      r_key_last <= '0;
    end else begin
      r_key_s1   <= keycode;
      r_key_s2   <= r_key_s1;
      r_key_s3   <= r_key_s2;
      if (r_key_s2 == r_key_s3)
        r_key_filt <= r_key_s2;
      r_key_last <= r_key_filt;
    end
  end

  logic [3:0] w_map;
  logic       w_mapped, w_dir, w_change, w_press, w_rep;

  assign w_map    = f_map(r_key_filt);
  assign w_mapped = w_map[3];
  assign w_dir    = w_mapped && !w_map[2];
  assign w_change = (r_key_filt != r_key_last);
  assign w_press  = w_change && w_mapped;
  assign held     = w_dir;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic          r_vs_s1, r_vs_s2, r_vs_s3;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_frame;

  assign w_frame = r_vs_s2 && !r_vs_s3;
  // A key change in the same cycle wins; the restarted FSM makes the repeat moot
  assign w_rep   = !w_change && (r_state != S_IDLE) && w_frame && (r_cnt == CW'(1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_s3 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_vs_s1 <= vs;
      r_vs_s2 <= r_vs_s1;
      r_vs_s3 <= r_vs_s2;
      if (w_change) begin
        r_state <= w_dir ? S_DELAY : S_IDLE;
        r_cnt   <= w_dir ? CW'(REPEAT_DELAY) : '0;
      end else if (r_state != S_IDLE && w_frame) begin
        if (r_cnt == CW'(1)) begin
          r_state <= S_REPEAT;
          r_cnt   <= CW'(REPEAT_RATE);
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end
`else
  logic [CW:0] w_unused_cfg;

  assign w_rep        = 1'b0;
  assign w_unused_cfg = {vs, {CW{1'b0}}};
`endif

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_req, w_full, w_pop, w_push;

  assign w_req  = w_press || w_rep;
  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = (r_count != '0) && ev.ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push = w_req && (!w_full || w_pop);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_map[2:0];
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_req && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign ev.ev_valid = (r_count != '0);
  assign ev.ev_code  = r_mem[r_rptr];
  assign overflow    = r_overflow;
endmodule
